// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
//
// Accepts one 32-bit instruction word per cycle over a valid/ready handshake,
// decodes its immediate format and XLEN-wide immediate, and presents the
// result from a registered output stage backed by a one-entry skid register.
// Unsupported encodings are flagged and a saturating count of illegal entries
// handed to the consumer is kept.
//
// Parameters:
//   XLEN  - datapath width, 32 or 64
//   TAG_W - width of the sideband tag carried alongside each word
//   CNT_W - width of the saturating illegal-entry counter
//
// Ports:
//   clk          clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   flush        synchronous kill of the main and skid entries
//   in_valid     instruction word offered
//   in_ready     block can accept (skid register empty)
//   in_instr     instruction word
//   in_tag       sideband tag
//   out_valid    decoded entry available
//   out_ready    consumer accepts
//   out_imm      decoded immediate
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
//   out_illegal  unsupported opcode or encoding
//   out_tag      tag of the presented entry
//   illegal_cnt  saturating count of illegal entries handed out
//
// Build option:
//   IMM_ZICSR_EN - when defined, CSRRWI/CSRRSI/CSRRCI decode as ZIMM with the
//                  5-bit zero-extended immediate; otherwise they decode as I.

module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit Rv64 = (XLEN == 64);

  typedef enum logic [2:0] {
    FmtNone  = 3'd0,
    FmtI     = 3'd1,
    FmtS     = 3'd2,
    FmtB     = 3'd3,
    FmtU     = 3'd4,
    FmtJ     = 3'd5,
    FmtShamt = 3'd6,
    FmtZimm  = 3'd7
  } fmt_e;

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpOp32    = 7'b0111011;

  // ---------------------------------------------------------------------------
  // Decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_z;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Replication counts are arranged so none of them can be zero at XLEN = 32.
  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};
  assign imm_z = {{(XLEN-5){1'b0}}, in_instr[19:15]};

  // A 6-bit shift amount only exists for OP-IMM on RV64; OP-IMM-32 and RV32
  // use 5 bits, with instr[25] reserved (and rejected on RV32 below).
  always_comb begin
    imm_sh = '0;
    if (Rv64 && (opcode == OpOpImm)) begin
      imm_sh[5:0] = in_instr[25:20];
    end else begin
      imm_sh[4:0] = in_instr[24:20];
    end
  end

  always_comb begin
    dec_fmt = FmtNone;
    dec_ill = 1'b0;
    case (opcode)
      OpLui, OpAuipc:             dec_fmt = FmtU;
      OpJal:                      dec_fmt = FmtJ;
      OpJalr, OpLoad, OpMiscMem:  dec_fmt = FmtI;
      OpBranch:                   dec_fmt = FmtB;
      OpStore:                    dec_fmt = FmtS;
      OpOp:                       dec_fmt = FmtNone;
      OpOpImm: begin
        if (is_shift) begin
          dec_fmt = FmtShamt;
          if (!Rv64 && in_instr[25]) begin
            dec_ill = 1'b1;
          end
        end else begin
          dec_fmt = FmtI;
        end
      end
      OpOpImm32: begin
        if (!Rv64) begin
          dec_ill = 1'b1;
        end else if (is_shift) begin
          dec_fmt = FmtShamt;
        end else begin
          dec_fmt = FmtI;
        end
      end
      OpOp32: begin
        if (!Rv64) begin
          dec_ill = 1'b1;
        end
      end
      OpSystem: begin
`ifdef IMM_ZICSR_EN
        dec_fmt = funct3[2] ? FmtZimm : FmtI;
`else
        dec_fmt = FmtI;
`endif
      end
      default:                    dec_ill = 1'b1;
    endcase

    // Every listed opcode already has [1:0] = 11; kept explicit for clarity.
    if (in_instr[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end
    if (dec_ill) begin
      dec_fmt = FmtNone;
    end
  end

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FmtI:     dec_imm = imm_i;
      FmtS:     dec_imm = imm_s;
      FmtB:     dec_imm = imm_b;
      FmtU:     dec_imm = imm_u;
      FmtJ:     dec_imm = imm_j;
      FmtShamt: dec_imm = imm_sh;
      FmtZimm:  dec_imm = imm_z;
      default:  dec_imm = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main output register plus one skid register
  // ---------------------------------------------------------------------------
  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q;
  fmt_e             main_fmt_q;
  logic             main_ill_q;
  logic [TAG_W-1:0] main_tag_q;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q;
  fmt_e             skid_fmt_q;
  logic             skid_ill_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic             accept;
  logic             drain;
  logic             main_free;
  logic             main_load_in;
  logic             main_load_skid;
  logic             skid_load;

  // in_ready is a pure register output, so out_ready never reaches it.
  assign in_ready = !skid_valid_q;

  always_comb begin
    accept         = in_valid && in_ready && !flush;
    drain          = main_valid_q && out_ready;
    main_free      = !main_valid_q || drain;
    // The skid entry is older than anything arriving now, so it wins main.
    main_load_skid = main_free && skid_valid_q && !flush;
    main_load_in   = main_free && !skid_valid_q && accept;
    skid_load      = !main_free && accept;

    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (main_free) begin
        main_valid_d = skid_valid_q || accept;
      end
      if (skid_load) begin
        skid_valid_d = 1'b1;
      end else if (main_load_skid) begin
        skid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= FmtNone;
      main_ill_q   <= 1'b0;
      main_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      if (main_load_skid) begin
        main_imm_q <= skid_imm_q;
        main_fmt_q <= skid_fmt_q;
        main_ill_q <= skid_ill_q;
        main_tag_q <= skid_tag_q;
      end else if (main_load_in) begin
        main_imm_q <= dec_imm;
        main_fmt_q <= dec_fmt;
        main_ill_q <= dec_ill;
        main_tag_q <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FmtNone;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      if (skid_load) begin
        skid_imm_q <= dec_imm;
        skid_fmt_q <= dec_fmt;
        skid_ill_q <= dec_ill;
        skid_tag_q <= in_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating illegal counter; a handshake during flush still counts.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;

  assign cnt_inc = main_valid_q && out_ready && main_ill_q && (cnt_q != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_imm_q;
  assign out_fmt     = main_fmt_q;
  assign out_illegal = main_ill_q;
  assign out_tag     = main_tag_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  // XLEN=32 instance with a small counter so saturation is reachable.
  logic        rdy32, vld32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  tag32;
  logic [3:0]  cnt32;

  // XLEN=64 instance on the same stimulus.
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  tag64;
  logic [15:0] cnt64;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] s_instr [5];
  logic [2:0]  s_fmt   [5];
  logic [31:0] s_imm   [5];

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(4)) u_dut32 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (rdy32),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (vld32),
    .out_ready   (out_ready),
    .out_imm     (imm32),
    .out_fmt     (fmt32),
    .out_illegal (ill32),
    .out_tag     (tag32),
    .illegal_cnt (cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) u_dut64 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (rdy64),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (vld64),
    .out_ready   (out_ready),
    .out_imm     (imm64),
    .out_fmt     (fmt64),
    .out_illegal (ill64),
    .out_tag     (tag64),
    .illegal_cnt (cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [7:0] tag);
    in_valid = v;
    in_instr = instr;
    in_tag   = tag;
  endtask

  initial begin
    s_instr[0] = 32'h12345037; s_fmt[0] = 3'd4; s_imm[0] = 32'h12345000;
    s_instr[1] = 32'hFFC10113; s_fmt[1] = 3'd1; s_imm[1] = 32'hFFFFFFFC;
    s_instr[2] = 32'h00A12623; s_fmt[2] = 3'd2; s_imm[2] = 32'h0000000C;
    s_instr[3] = 32'hFE0008E3; s_fmt[3] = 3'd3; s_imm[3] = 32'hFFFFFFF0;
    s_instr[4] = 32'h0080006F; s_fmt[4] = 3'd5; s_imm[4] = 32'h00000008;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    tick();
    tick();
    check("rst_valid", 64'(vld32), 64'd0);
    check("rst_imm", 64'(imm32), 64'd0);
    check("rst_fmt", 64'(fmt32), 64'd0);
    check("rst_ill", 64'(ill32), 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    check("rst_cnt", 64'(cnt32), 64'd0);
    check("rst_ready", 64'(rdy32), 64'd1);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s_instr[i], 8'(i + 1));
      tick();
      check($sformatf("stream_valid_%0d", i), 64'(vld32), 64'd1);
      check($sformatf("stream_fmt_%0d", i), 64'(fmt32), 64'(s_fmt[i]));
      check($sformatf("stream_imm_%0d", i), 64'(imm32), 64'(s_imm[i]));
      check($sformatf("stream_tag_%0d", i), 64'(tag32), 64'(i + 1));
      if (i == 1) check("stream_imm64_sext", imm64, 64'hFFFFFFFFFFFFFFFC);
    end
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("stream_drained", 64'(vld32), 64'd0);

    // Back-pressure: two words held, skid fills, then released in order.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 8'h11);
    tick();
    check("bp_first_valid", 64'(vld32), 64'd1);
    check("bp_ready_after_1", 64'(rdy32), 64'd1);
    drive(1'b1, 32'h00200113, 8'h22);
    tick();
    check("bp_ready_after_2", 64'(rdy32), 64'd0);
    check("bp_hold_tag", 64'(tag32), 64'h11);
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("bp_stable_tag", 64'(tag32), 64'h11);
    check("bp_stable_imm", 64'(imm32), 64'd1);
    check("bp_stable_ready", 64'(rdy32), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_second_valid", 64'(vld32), 64'd1);
    check("bp_second_tag", 64'(tag32), 64'h22);
    check("bp_second_imm", 64'(imm32), 64'd2);
    check("bp_ready_back", 64'(rdy32), 64'd1);
    tick();
    check("bp_empty", 64'(vld32), 64'd0);

    // slli with instr[25]=1: illegal on RV32, shamt 32 on RV64.
    out_ready = 1'b0;
    drive(1'b1, 32'h02009093, 8'h33);
    tick();
    check("slli32_ill", 64'(ill32), 64'd1);
    check("slli32_imm", 64'(imm32), 64'd0);
    check("slli32_fmt", 64'(fmt32), 64'd0);
    check("slli64_fmt", 64'(fmt64), 64'd6);
    check("slli64_imm", imm64, 64'h20);
    check("slli64_ill", 64'(ill64), 64'd0);
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("cnt_no_hs", 64'(cnt32), 64'd0);
    out_ready = 1'b1;
    tick();
    check("cnt_on_hs", 64'(cnt32), 64'd1);

    // Unknown opcode and OP-IMM-32 (addiw) on RV32.
    drive(1'b1, 32'h0000007F, 8'h44);
    tick();
    check("op7f_ill", 64'(ill32), 64'd1);
    check("op7f_tag", 64'(tag32), 64'h44);
    check("op7f_ill64", 64'(ill64), 64'd1);
    drive(1'b1, 32'h0010009B, 8'h45);
    tick();
    check("addiw32_ill", 64'(ill32), 64'd1);
    check("addiw64_fmt", 64'(fmt64), 64'd1);
    check("addiw64_imm", imm64, 64'd1);
    check("cnt_after_7f", 64'(cnt32), 64'd2);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h0000007F, 8'(i));
      tick();
    end
    drive(1'b0, 32'h0, 8'h0);
    tick();
    tick();
    check("cnt32_sat", 64'(cnt32), 64'hF);
    check("cnt64_count", 64'(cnt64), 64'd17);

    // Flush with main and skid full and a word offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 8'h41);
    tick();
    drive(1'b1, 32'h00200113, 8'h42);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00300193, 8'h43);
    tick();
    check("flush_valid", 64'(vld32), 64'd0);
    check("flush_ready", 64'(rdy32), 64'd1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    out_ready = 1'b1;
    tick();
    check("flush_dropped", 64'(vld32), 64'd0);

    // Flush while the block could accept: the offered word must be dropped.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 8'h51);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h00300193, 8'h52);
    tick();
    check("flush2_valid", 64'(vld32), 64'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 8'h0);
    tick();
    check("flush2_dropped", 64'(vld32), 64'd0);

    // CSRRWI x0, 0x300, 1.
    out_ready = 1'b1;
    drive(1'b1, 32'h3000D073, 8'h61);
    tick();
`ifdef IMM_ZICSR_EN
    check("csrrwi_fmt", 64'(fmt32), 64'd7);
    check("csrrwi_imm", 64'(imm32), 64'd1);
`else
    check("csrrwi_fmt", 64'(fmt32), 64'd1);
    check("csrrwi_imm", 64'(imm32), 64'h300);
`endif
    check("csrrwi_tag", 64'(tag32), 64'h61);

    // Asynchronous reset mid-stream with both entries occupied.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 8'h71);
    tick();
    drive(1'b1, 32'h00200113, 8'h72);
    tick();
    drive(1'b0, 32'h0, 8'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(vld32), 64'd0);
    check("arst_imm", 64'(imm32), 64'd0);
    check("arst_fmt", 64'(fmt32), 64'd0);
    check("arst_tag", 64'(tag32), 64'd0);
    check("arst_cnt", 64'(cnt32), 64'd0);
    check("arst_ready", 64'(rdy32), 64'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("arst_no_partial", 64'(vld32), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
